// File: rtl/mmcm_clkgen_model.sv
`timescale 1ns/1ps
// Behavioural MMCM with two buffered outputs and a lock-qualified reset synchronizer.
// Simulation-only stand-in for the vendor clocking primitives; all timing is in real ns.
module mmcm_clkgen_model #(
    parameter int  DIVCLK_DIVIDE    = 5,
    parameter real CLKFBOUT_MULT_F  = 45.0,
    parameter real CLKIN1_PERIOD    = 10.0,
    parameter real CLKOUT0_DIVIDE_F = 4.5,
    parameter int  CLKOUT1_DIVIDE   = 5,
    parameter int  LOCK_CYCLES      = 64,
    parameter real PERIOD_TOL_PCT   = 1.0,
    parameter int  SRST_STAGES      = 3
) (
    input  logic clk_in,
    input  logic areset,
    output logic clk_out0,
    output logic clk_out1,
    output logic pll_lock,
    output logic srst
);

    localparam real FVCO_MHZ = 1000.0 * CLKFBOUT_MULT_F / (CLKIN1_PERIOD * real'(DIVCLK_DIVIDE));
    localparam real T0_NS    = CLKIN1_PERIOD * real'(DIVCLK_DIVIDE) * CLKOUT0_DIVIDE_F / CLKFBOUT_MULT_F;
    localparam real T1_NS    = CLKIN1_PERIOD * real'(DIVCLK_DIVIDE) * real'(CLKOUT1_DIVIDE) / CLKFBOUT_MULT_F;
    // Half-periods snapped to the 1 ps simulation grid so both phases are identical.
    localparam real HALF0_NS = real'($rtoi(T0_NS * 500.0 + 0.5)) / 1000.0;
    localparam real HALF1_NS = real'($rtoi(T1_NS * 500.0 + 0.5)) / 1000.0;
    localparam real TOL_NS   = CLKIN1_PERIOD * PERIOD_TOL_PCT / 100.0;
    localparam real WDOG_NS  = 2.0 * CLKIN1_PERIOD;

    if (DIVCLK_DIVIDE < 1 || DIVCLK_DIVIDE > 106) begin : g_bad_divclk
        $fatal(1, "mmcm_clkgen_model: DIVCLK_DIVIDE out of range 1..106");
    end
    if (CLKFBOUT_MULT_F < 2.0 || CLKFBOUT_MULT_F > 64.0) begin : g_bad_mult
        $fatal(1, "mmcm_clkgen_model: CLKFBOUT_MULT_F out of range 2.0..64.0");
    end
    if (CLKOUT0_DIVIDE_F < 1.0 || CLKOUT0_DIVIDE_F > 128.0) begin : g_bad_div0
        $fatal(1, "mmcm_clkgen_model: CLKOUT0_DIVIDE_F out of range 1.0..128.0");
    end
    if (CLKOUT1_DIVIDE < 1 || CLKOUT1_DIVIDE > 128) begin : g_bad_div1
        $fatal(1, "mmcm_clkgen_model: CLKOUT1_DIVIDE out of range 1..128");
    end
    if (CLKIN1_PERIOD <= 0.0 || LOCK_CYCLES < 1 || SRST_STAGES < 1) begin : g_bad_misc
        $fatal(1, "mmcm_clkgen_model: bad CLKIN1_PERIOD, LOCK_CYCLES or SRST_STAGES");
    end
    if (FVCO_MHZ < 400.0 || FVCO_MHZ > 1080.0) begin : g_bad_vco
        $fatal(1, "mmcm_clkgen_model: VCO frequency outside 400..1080 MHz");
    end

    logic                   lock_q;
    logic                   have_last_q;
    int                     count_q;
    int                     edge_cnt_q;
    real                    last_rise_q;
    real                    deadline_q;
    logic                   timed_out_q;
    logic                   clk0_q;
    logic                   clk1_q;
    logic                   arst_n;
    logic [SRST_STAGES-1:0] pipe_q;
    logic                   srst_q;
    real                    rel_time;

    function automatic logic in_tol(input real period_ns);
        return (period_ns >= CLKIN1_PERIOD - TOL_NS) && (period_ns <= CLKIN1_PERIOD + TOL_NS);
    endfunction

    // Period qualification: the first edge after reset only timestamps.
    always @(posedge clk_in or posedge areset) begin
        if (areset) begin
            have_last_q <= 1'b0;
            count_q     <= 0;
            lock_q      <= 1'b0;
        end else begin
            if (have_last_q) begin
                if (in_tol($realtime - last_rise_q)) begin
                    if (count_q >= LOCK_CYCLES - 1) begin
                        count_q <= LOCK_CYCLES;
                        lock_q  <= 1'b1;
                    end else begin
                        count_q <= count_q + 1;
                    end
                end else begin
                    count_q <= 0;
                    lock_q  <= 1'b0;
                end
            end
            have_last_q <= 1'b1;
            last_rise_q <= $realtime;
            deadline_q  <= $realtime + WDOG_NS;
            edge_cnt_q  <= edge_cnt_q + 1;
        end
    end

    // Missing-edge detector; the long gap also resets the count at the next edge.
    always begin : watchdog
        if (areset || !have_last_q) begin
            timed_out_q <= 1'b0;
            @(edge_cnt_q or areset);
        end else if ($realtime < deadline_q - 0.0005) begin
            timed_out_q <= 1'b0;
            #(deadline_q - $realtime);
        end else begin
            timed_out_q <= 1'b1;
            @(edge_cnt_q or areset);
        end
    end

    assign pll_lock = lock_q & ~timed_out_q & ~areset;

    // Each output always completes a full high and low phase, so no runt pulses.
    always begin : gen_out0
        clk0_q <= 1'b0;
        wait (pll_lock);
        while (pll_lock) begin
            clk0_q <= 1'b1;
            #(HALF0_NS);
            clk0_q <= 1'b0;
            #(HALF0_NS);
        end
    end

    always begin : gen_out1
        clk1_q <= 1'b0;
        wait (pll_lock);
        while (pll_lock) begin
            clk1_q <= 1'b1;
            #(HALF1_NS);
            clk1_q <= 1'b0;
            #(HALF1_NS);
        end
    end

    assign clk_out0 = clk0_q & ~areset;
    assign clk_out1 = clk1_q & ~areset;

    assign arst_n = ~areset & pll_lock;

    // The clk_out0 rise coincident with lock release is not counted (recovery).
    always begin : reset_sync
        if (!arst_n) begin
            pipe_q <= '1;
            srst_q <= 1'b1;
            wait (arst_n);
            rel_time = $realtime;
        end else begin
            @(posedge clk_out0 or negedge arst_n);
            if (arst_n && ($realtime > rel_time)) begin
                srst_q <= pipe_q[SRST_STAGES-1];
                pipe_q <= pipe_q << 1;
            end
        end
    end

    assign srst = srst_q | ~arst_n;

endmodule

// File: tb/tb_mmcm_clkgen_model.sv
`timescale 1ns/1ps
// Directed bench for mmcm_clkgen_model: lock timing, output periods, srst release,
// areset pulse, clk_in stall and off-frequency input.
module tb_mmcm_clkgen_model;

    logic clk_in = 1'b0;
    logic areset = 1'b1;
    logic clk_out0;
    logic clk_out1;
    logic pll_lock;
    logic srst;

    real half_ns = 5.0;
    bit  clk_run = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    real lock_t      = -1.0;
    real srst_fall_t = -1.0;
    real r0_prev = 0.0, r0_last = 0.0, f0_last = 0.0;
    real r1_prev = 0.0, r1_last = 0.0, f1_last = 0.0;
    int  n_r0 = 0, n_r1 = 0;
    int  snap_r0, snap_r1;

    mmcm_clkgen_model dut (
        .clk_in   (clk_in),
        .areset   (areset),
        .clk_out0 (clk_out0),
        .clk_out1 (clk_out1),
        .pll_lock (pll_lock),
        .srst     (srst)
    );

    always begin
        if (clk_run) begin
            #(half_ns);
            clk_in = ~clk_in;
        end else begin
            clk_in = 1'b0;
            wait (clk_run);
        end
    end

    always @(posedge pll_lock) lock_t = $realtime;
    always @(negedge srst) srst_fall_t = $realtime;
    always @(posedge clk_out0) begin r0_prev = r0_last; r0_last = $realtime; n_r0++; end
    always @(negedge clk_out0) f0_last = $realtime;
    always @(posedge clk_out1) begin r1_prev = r1_last; r1_last = $realtime; n_r1++; end
    always @(negedge clk_out1) f1_last = $realtime;

    function automatic longint ps(input real t_ns);
        return longint'(t_ns * 1000.0);
    endfunction

    task automatic at(input real t_ns);
        #(t_ns - $realtime);
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        at(10.0);
        chk("reset_lock", longint'(pll_lock), 0);
        chk("reset_clk0", longint'(clk_out0), 0);
        chk("reset_clk1", longint'(clk_out1), 0);
        chk("reset_srst", longint'(srst), 1);
        $display("step: reset state checked at %0t", $time);

        // First lock: clk_in rises at 55 (timestamp) ... 695 (64th good period)
        at(50.0);
        areset = 1'b0;
        at(690.0);
        chk("lock_early", longint'(pll_lock), 0);
        at(696.0);
        chk("lock_set", longint'(pll_lock), 1);
        chk("lock_time_ps", ps(lock_t), 695000);
        chk("clk0_high_at_lock", longint'(clk_out0), 1);
        chk("clk1_high_at_lock", longint'(clk_out1), 1);
        chk("srst_at_lock", longint'(srst), 1);
        at(712.0);
        chk("srst_after_3_rises", longint'(srst), 1);
        at(716.0);
        chk("srst_after_4_rises", longint'(srst), 0);
        chk("srst_fall_ps", ps(srst_fall_t), 715000);
        $display("step: first lock at %0t ps, srst release at %0t ps", ps(lock_t), ps(srst_fall_t));

        at(750.0);
        chk("clk0_period_ps", ps(r0_last - r0_prev), 5000);
        chk("clk0_high_ps", ps(f0_last - r0_last), 2500);
        chk("clk1_period_ps", ps(r1_last - r1_prev), 5556);
        chk("clk1_high_ps", ps(f1_last - r1_last), 2778);
        chk("clk1_phase_ps", ps(r1_last), 745004);
        $display("step: periods clk0=%0d ps clk1=%0d ps", ps(r0_last - r0_prev), ps(r1_last - r1_prev));

        // Mid-run areset pulse of 20 ns
        at(801.0);
        areset = 1'b1;
        at(802.0);
        chk("areset_lock", longint'(pll_lock), 0);
        chk("areset_clk0", longint'(clk_out0), 0);
        chk("areset_clk1", longint'(clk_out1), 0);
        chk("areset_srst", longint'(srst), 1);
        at(821.0);
        areset = 1'b0;
        at(1460.0);
        chk("relock_early", longint'(pll_lock), 0);
        at(1466.0);
        chk("relock_set", longint'(pll_lock), 1);
        chk("relock_time_ps", ps(lock_t), 1465000);
        at(1484.0);
        chk("relock_srst_held", longint'(srst), 1);
        at(1486.0);
        chk("relock_srst_rel", longint'(srst), 0);
        $display("step: relock after areset pulse at %0t ps", ps(lock_t));

        // clk_in stall: last rise at 1505, watchdog expires at 1525
        at(1507.0);
        clk_run = 1'b0;
        at(1524.0);
        chk("stall_lock_held", longint'(pll_lock), 1);
        at(1526.0);
        chk("stall_lock_lost", longint'(pll_lock), 0);
        chk("stall_srst", longint'(srst), 1);
        at(1530.0);
        chk("stall_clk0", longint'(clk_out0), 0);
        chk("stall_clk1", longint'(clk_out1), 0);
        snap_r0 = n_r0;
        at(1540.0);
        clk_run = 1'b1;
        at(1560.0);
        chk("stall_clk0_parked", longint'(n_r0 - snap_r0), 0);
        chk("resume_lock", longint'(pll_lock), 0);
        at(2180.0);
        chk("resume_lock_early", longint'(pll_lock), 0);
        at(2186.0);
        chk("resume_lock_set", longint'(pll_lock), 1);
        chk("resume_lock_time_ps", ps(lock_t), 2185000);
        $display("step: relock after clk_in stall at %0t ps", ps(lock_t));

        // Off-frequency reference (12 ns) never locks
        at(2202.0);
        areset  = 1'b1;
        half_ns = 6.0;
        at(2230.0);
        areset  = 1'b0;
        snap_r0 = n_r0;
        snap_r1 = n_r1;
        at(3200.0);
        chk("offfreq_lock", longint'(pll_lock), 0);
        chk("offfreq_clk0_rises", longint'(n_r0 - snap_r0), 0);
        chk("offfreq_clk1_rises", longint'(n_r1 - snap_r1), 0);
        chk("offfreq_srst", longint'(srst), 1);
        $display("step: off-frequency reference, pll_lock=%0b", pll_lock);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
